// File: rtl/frac_lut_k_shadow_cfg.sv
// K-input fracturable LUT with a scan-loaded config chain and an atomically committed shadow copy.
// Optional even-parity check on commit is enabled by defining FRAC_LUT_PARITY_EN.
module frac_lut_k_shadow_cfg #(
  parameter int K = 6
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic [0:K-1] in,
  input  logic         ccff_head,
  input  logic         ccff_en,
  input  logic         cfg_commit,
  output logic [0:1]   lut_frac_out,
  output logic         lut_out,
  output logic         ccff_tail,
  output logic         cfg_valid,
  output logic         cfg_err
);
  localparam int N = 2**K;
`ifdef FRAC_LUT_PARITY_EN
  localparam int L = N + 2;
`else
  localparam int L = N + 1;
`endif
  localparam int CW = $clog2(L + 1);

  typedef enum logic {UNCFG, ACTIVE} state_t;

  logic [0:L-1]  chain;
  logic [CW-1:0] cnt;
  logic [0:N-1]  sh_sram;
  logic          sh_mode;
  state_t        state;
  logic          parity_ok;
  logic          commit_ok;

`ifdef FRAC_LUT_PARITY_EN
  assign parity_ok = ~^chain;
`else
  assign parity_ok = 1'b1;
`endif

  // Commit judges the pre-edge chain and count, even when a shift lands on the same edge.
  assign commit_ok = (cnt == CW'(L)) && parity_ok;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      chain <= '0;
      cnt   <= '0;
    end else begin
      if (ccff_en)
        chain <= {ccff_head, chain[0:L-2]};
      if (cfg_commit)
        cnt <= ccff_en ? CW'(1) : '0;
      else if (ccff_en && cnt != CW'(L))
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state   <= UNCFG;
      sh_sram <= '0;
      sh_mode <= 1'b0;
      cfg_err <= 1'b0;
    end else if (cfg_commit) begin
      if (commit_ok) begin
        sh_sram <= chain[0:N-1];
        sh_mode <= chain[N];
        cfg_err <= 1'b0;
        state   <= ACTIVE;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  assign cfg_valid = (state == ACTIVE);
  assign ccff_tail = chain[L-1];

  logic [K-2:0] idx;
  logic [K-1:0] hi_idx;
  logic         lo, hi;

  // in[0] is the index LSB even though the port is declared ascending.
  always_comb begin
    idx = '0;
    for (int j = 0; j < K-1; j++) idx[j] = in[j];
  end

  assign hi_idx = {1'b1, idx};
  assign lo     = sh_sram[{1'b0, idx}];
  assign hi     = sh_sram[hi_idx];

  assign lut_frac_out = cfg_valid ? {lo, hi} : 2'b00;
  assign lut_out      = cfg_valid & (sh_mode ? lo : (in[K-1] ? hi : lo));
endmodule

// File: tb/tb_frac_lut_k_shadow_cfg.sv
// Directed bench for frac_lut_k_shadow_cfg (K=4): scoreboard of expected outputs plus fixed checks.
module tb_frac_lut_k_shadow_cfg;
  localparam int K = 4;
  localparam int N = 16;
`ifdef FRAC_LUT_PARITY_EN
  localparam int LT = N + 2;
`else
  localparam int LT = N + 1;
`endif

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic [0:3] tin;
  logic       ccff_head, ccff_en, cfg_commit;
  logic [0:1] lut_frac_out;
  logic       lut_out, ccff_tail, cfg_valid, cfg_err;

  frac_lut_k_shadow_cfg #(.K(K)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .in(tin),
    .ccff_head(ccff_head), .ccff_en(ccff_en), .cfg_commit(cfg_commit),
    .lut_frac_out(lut_frac_out), .lut_out(lut_out), .ccff_tail(ccff_tail),
    .cfg_valid(cfg_valid), .cfg_err(cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [0:17] m_chain;
  int          m_cnt;
  logic [0:15] m_sh;
  logic        m_mode, m_valid, m_err;
  logic [5:0]  exp_q[$];

  logic [0:17] and4, and4_bad, or4;

  function automatic logic [5:0] model_out();
    int idx;
    logic lo, hi, lut;
    idx = int'(tin[0]) + 2 * int'(tin[1]) + 4 * int'(tin[2]);
    lo  = m_sh[idx];
    hi  = m_sh[8 + idx];
    lut = m_mode ? lo : (tin[3] ? hi : lo);
    if (!m_valid) begin
      lut = 1'b0; lo = 1'b0; hi = 1'b0;
    end
    return {lut, lo, hi, m_valid, m_err, m_chain[LT-1]};
  endfunction

  function automatic logic [0:17] mk(logic [0:15] s, logic mode, logic flip);
    logic [0:17] f;
    f = '0;
    f[0:15] = s;
    f[16] = mode;
`ifdef FRAC_LUT_PARITY_EN
    f[17] = (^{s, mode}) ^ flip;
`else
    f[17] = flip & 1'b0;
`endif
    return f;
  endfunction

  task automatic model_reset();
    m_chain = '0; m_cnt = 0; m_sh = '0;
    m_mode = 1'b0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic check(string tag);
    logic [5:0] e, o;
    e = exp_q.pop_front();
    o = {lut_out, lut_frac_out[0], lut_frac_out[1], cfg_valid, cfg_err, ccff_tail};
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed {lut,lo,hi,valid,err,tail}=%b expected %b", tag, o, e);
    end
  endtask

  task automatic chk(string tag, logic [7:0] o, logic [7:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step(logic h, logic en, logic cm, string tag);
    logic par;
    ccff_head = h; ccff_en = en; cfg_commit = cm;
    par = 1'b0;
`ifdef FRAC_LUT_PARITY_EN
    for (int i = 0; i < LT; i++) par ^= m_chain[i];
`endif
    if (cm) begin
      if (m_cnt == LT && !par) begin
        m_sh = m_chain[0:15]; m_mode = m_chain[16];
        m_valid = 1'b1; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (en) m_chain = {h, m_chain[0:16]};
    if (cm) m_cnt = en ? 1 : 0;
    else if (en && m_cnt < LT) m_cnt++;
    exp_q.push_back(model_out());
    @(posedge prog_clk);
    #1;
    ccff_en = 1'b0; cfg_commit = 1'b0;
    check(tag);
  endtask

  task automatic set_in(logic [0:3] v, string tag);
    tin = v;
    exp_q.push_back(model_out());
    #1;
    check(tag);
  endtask

  task automatic shift_frame(logic [0:17] f, int nbits);
    for (int i = 0; i < nbits; i++) step(f[LT-1-i], 1'b1, 1'b0, "shift");
  endtask

  initial begin
    and4     = mk(16'h0001, 1'b0, 1'b0);
    and4_bad = mk(16'h0001, 1'b0, 1'b1);
    or4      = mk(16'h7FFF, 1'b0, 1'b0);

    pReset = 1'b0; tin = 4'hF;
    ccff_head = 1'b0; ccff_en = 1'b0; cfg_commit = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    #2;
    check("reset_state");
    chk("reset_lut_out", {7'd0, lut_out}, 8'd0);
    chk("reset_frac", {6'd0, lut_frac_out}, 8'd0);
    #10 pReset = 1'b1;

    // AND4 load and commit
    shift_frame(and4, LT);
    step(1'b0, 1'b0, 1'b1, "commit_and4");
    chk("and4_valid", {7'd0, cfg_valid}, 8'd1);
    chk("and4_err", {7'd0, cfg_err}, 8'd0);
    set_in(4'hF, "and4_inF");
    chk("and4_inF_lut", {7'd0, lut_out}, 8'd1);
    chk("and4_inF_frac", {6'd0, lut_frac_out}, 8'd1);
    set_in(4'h7, "and4_in7");
    chk("and4_in7_lut", {7'd0, lut_out}, 8'd0);

`ifdef FRAC_LUT_PARITY_EN
    shift_frame(and4_bad, LT);
    step(1'b0, 1'b0, 1'b1, "commit_badpar");
    chk("badpar_err", {7'd0, cfg_err}, 8'd1);
    chk("badpar_valid", {7'd0, cfg_valid}, 8'd1);
    set_in(4'hF, "badpar_shadow");
    chk("badpar_lut", {7'd0, lut_out}, 8'd1);
`endif

    // Incomplete load rejected, full load recovers
    shift_frame(and4, 10);
    step(1'b0, 1'b0, 1'b1, "commit_short");
    chk("short_err", {7'd0, cfg_err}, 8'd1);
    shift_frame(and4, LT);
    step(1'b0, 1'b0, 1'b1, "commit_full");
    chk("full_err", {7'd0, cfg_err}, 8'd0);

    // Shift OR4 while AND4 is live; output must not move until commit
    set_in(4'h1, "live_in1");
    shift_frame(or4, LT);
    chk("or4_precommit_lut", {7'd0, lut_out}, 8'd0);
    step(1'b0, 1'b0, 1'b1, "commit_or4");
    chk("or4_lut", {7'd0, lut_out}, 8'd1);
    set_in(4'h0, "or4_in0");
    chk("or4_in0_lut", {7'd0, lut_out}, 8'd0);

    // Commit with a concurrent shift, then a back-to-back commit
    shift_frame(and4, LT);
    step(1'b1, 1'b1, 1'b1, "commit_and_shift");
    set_in(4'h1, "cs_in1");
    chk("cs_lut", {7'd0, lut_out}, 8'd0);
    chk("cs_err", {7'd0, cfg_err}, 8'd0);
    step(1'b0, 1'b0, 1'b1, "commit_again");
    chk("again_err", {7'd0, cfg_err}, 8'd1);
    chk("again_valid", {7'd0, cfg_valid}, 8'd1);
    set_in(4'hF, "again_shadow");

    // Asynchronous reset in the middle of a shift
    shift_frame(or4, 5);
    pReset = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    #1;
    check("reset_midshift");
    chk("midreset_valid", {7'd0, cfg_valid}, 8'd0);
    #2 pReset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
